// File: rtl/inv_pkg.sv
// Shared types and defaults for the inverse-result word serializer.
// The block is emitted as WORDS_PER_BLK words, most significant word first.
package inv_pkg;

    localparam int DATA_W        = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = DATA_W / WORD_W;

    typedef logic [DATA_W-1:0] block_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/inv_blk_fifo.sv
// Small register FIFO of whole result blocks; head is readable without a pop.
// Full/empty come from the registered count, so a push while full is refused even if a pop happens.
module inv_blk_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import inv_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/inv_word_serializer.sv
// Buffers completed inverse results and streams each one as WORD_W-bit words, MSW first.
// Word valid/data/last are derived only from registers, never from word_ready_i.
module inv_word_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk_valid_i,
    input  logic [DATA_W-1:0]        blk_data_i,
    output logic                     blk_ready_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic [WORD_W-1:0]        word_data_o,
    output logic                     word_last_o,
    output logic                     ovf_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import inv_pkg::*;

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    ser_state_e        state_reg;
    logic [IW-1:0]     idx_reg;
    logic              ovf_reg;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              push_ok;
    logic              pop_word;
    logic [WORD_W-1:0] words [NWORDS];

    inv_blk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (blk_valid_i),
        .push_data (blk_data_i),
        .pop       (pop_word),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign words[gi] = head_data[DATA_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    assign blk_ready_o  = !fifo_full;
    assign push_ok      = blk_valid_i && !fifo_full;
    assign word_valid_o = (state_reg == SEND);
    assign word_last_o  = word_valid_o && (idx_reg == LAST_IDX);
    assign word_data_o  = word_valid_o ? words[idx_reg] : '0;
    assign pop_word     = word_last_o && word_ready_i;
    assign ovf_o        = ovf_reg;
    assign count_o      = fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (blk_valid_i && fifo_full) begin
                ovf_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    // The pushed block lands in the FIFO at this edge, so word 0 is valid next cycle.
                    if (push_ok || !fifo_empty) begin
                        state_reg <= SEND;
                        idx_reg   <= '0;
                    end
                end
                SEND: begin
                    if (word_ready_i) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg <= '0;
                            if (fifo_count == CW'(1) && !push_ok) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_word_serializer.sv
// Directed bench for inv_word_serializer: vector table for the streaming cases,
// hand-written sequences for overflow, stalls, full push/pop collision and mid-block reset.
module tb_inv_word_serializer;

    logic         clk;
    logic         rst;
    logic         blk_valid_i;
    logic [127:0] blk_data_i;
    logic         blk_ready_o;
    logic         word_valid_o;
    logic         word_ready_i;
    logic [31:0]  word_data_o;
    logic         word_last_o;
    logic         ovf_o;
    logic [1:0]   count_o;

    int checks;
    int errors;

    inv_word_serializer #(
        .DATA_W (128),
        .WORD_W (32),
        .DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid_i  (blk_valid_i),
        .blk_data_i   (blk_data_i),
        .blk_ready_o  (blk_ready_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_data_o  (word_data_o),
        .word_last_o  (word_last_o),
        .ovf_o        (ovf_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         bv;
        logic [127:0] bd;
        logic         wr;
        logic         ev;
        logic [31:0]  ed;
        logic         el;
        logic [1:0]   ec;
        logic         ebr;
        logic         eovf;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    task automatic expect_word(input string nm, input logic [31:0] d, input logic l);
        check({nm, " valid"}, 128'(word_valid_o), 128'(1'b1));
        check({nm, " data"},  128'(word_data_o),  128'(d));
        check({nm, " last"},  128'(word_last_o),  128'(l));
        $display("%s: data=%h last=%0b count=%0d", nm, word_data_o, word_last_o, count_o);
    endtask

    task automatic expect_idle(input string nm);
        check({nm, " valid"}, 128'(word_valid_o), 128'(1'b0));
        check({nm, " data"},  128'(word_data_o),  128'(32'h0));
        check({nm, " last"},  128'(word_last_o),  128'(1'b0));
    endtask

    // Consumes a whole block with ready high, one word per cycle.
    task automatic drain_block(input string nm, input logic [127:0] b, input int first);
        for (int i = first; i < 4; i++) begin
            expect_word($sformatf("%s w%0d", nm, i), word_of(b, i), i == 3);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    localparam logic [127:0] BLK_A = 128'h0000000000000000FFFFFFFFFFFFFFFF;
    localparam logic [127:0] BLK_B = 128'h0123456789ABCDEF0011223344556677;
    localparam logic [127:0] BLK_C = 128'hFEDCBA9876543210FFEEDDCCBBAA9988;
    localparam logic [127:0] BLK_D = 128'h11111111222222223333333344444444;
    localparam logic [127:0] BLK_E = 128'h55555555666666667777777788888888;
    localparam logic [127:0] BLK_F = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    localparam logic [127:0] BLK_G = 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3;
    localparam logic [127:0] BLK_H = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] BLK_I = 128'h1112131415161718191A1B1C1D1E1F20;
    localparam logic [127:0] BLK_J = 128'h2122232425262728292A2B2C2D2E2F30;
    localparam logic [127:0] BLK_K = 128'hBADBADBADBADBADBADBADBADBADBAD00;
    localparam logic [127:0] BLK_L = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;

    initial begin
        logic [3:0] rdy_pat;
        int         ptr;

        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        blk_valid_i  = 1'b0;
        blk_data_i   = '0;
        word_ready_i = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        expect_idle("reset");
        check("reset blk_ready", 128'(blk_ready_o), 128'(1'b1));
        check("reset ovf",       128'(ovf_o),       128'(1'b0));
        check("reset count",     128'(count_o),     128'(2'd0));

        // Single block, then two back-to-back blocks with ready high
        vecs[0]  = '{1'b1, BLK_A, 1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, '0,    1'b1, 1'b1, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, '0,    1'b1, 1'b1, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, '0,    1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, '0,    1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, '0,    1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, BLK_B, 1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, BLK_C, 1'b1, 1'b1, 32'h01234567, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, '0,    1'b1, 1'b1, 32'h89ABCDEF, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, '0,    1'b1, 1'b1, 32'h00112233, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, '0,    1'b1, 1'b1, 32'h44556677, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, '0,    1'b1, 1'b1, 32'hFEDCBA98, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, '0,    1'b1, 1'b1, 32'h76543210, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, '0,    1'b1, 1'b1, 32'hFFEEDDCC, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, '0,    1'b1, 1'b1, 32'hBBAA9988, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, '0,    1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0};

        for (int v = 0; v < 16; v++) begin
            blk_valid_i  = vecs[v].bv;
            blk_data_i   = vecs[v].bd;
            word_ready_i = vecs[v].wr;
            $display("vec %0d: valid=%0b data=%h last=%0b count=%0d blk_ready=%0b ovf=%0b",
                     v, word_valid_o, word_data_o, word_last_o, count_o, blk_ready_o, ovf_o);
            check($sformatf("vec%0d valid", v),     128'(word_valid_o), 128'(vecs[v].ev));
            check($sformatf("vec%0d data", v),      128'(word_data_o),  128'(vecs[v].ed));
            check($sformatf("vec%0d last", v),      128'(word_last_o),  128'(vecs[v].el));
            check($sformatf("vec%0d count", v),     128'(count_o),      128'(vecs[v].ec));
            check($sformatf("vec%0d blk_ready", v), 128'(blk_ready_o),  128'(vecs[v].ebr));
            check($sformatf("vec%0d ovf", v),       128'(ovf_o),        128'(vecs[v].eovf));
            step();
        end
        blk_valid_i = 1'b0;

        // Fill while stalled, then overflow with a third block
        word_ready_i = 1'b0;
        blk_valid_i  = 1'b1;
        blk_data_i   = BLK_D;
        step();
        blk_data_i   = BLK_E;
        step();
        check("fill blk_ready", 128'(blk_ready_o), 128'(1'b0));
        check("fill count",     128'(count_o),     128'(2'd2));
        check("fill ovf",       128'(ovf_o),       128'(1'b0));
        blk_data_i = BLK_F;
        step();
        blk_valid_i = 1'b0;
        check("ovf set",   128'(ovf_o),   128'(1'b1));
        check("ovf count", 128'(count_o), 128'(2'd2));
        step();
        step();
        check("ovf held",  128'(ovf_o), 128'(1'b1));
        expect_word("stalled D", word_of(BLK_D, 0), 1'b0);
        word_ready_i = 1'b1;
        drain_block("ovf D", BLK_D, 0);
        drain_block("ovf E", BLK_E, 0);
        for (int i = 0; i < 3; i++) begin
            expect_idle($sformatf("after ovf idle%0d", i));
            step();
        end
        check("ovf still held", 128'(ovf_o), 128'(1'b1));

        // Ready toggling 1,0,0,1 during a block
        blk_valid_i = 1'b1;
        blk_data_i  = BLK_G;
        step();
        blk_valid_i = 1'b0;
        rdy_pat = 4'b1001;
        ptr     = 0;
        for (int cyc = 0; cyc < 24 && ptr < 4; cyc++) begin
            word_ready_i = rdy_pat[3 - (cyc % 4)];
            expect_word($sformatf("toggle c%0d", cyc), word_of(BLK_G, ptr), ptr == 3);
            if (word_ready_i && word_valid_o) ptr++;
            step();
        end
        check("toggle words done", 128'(ptr), 128'(4));
        expect_idle("toggle end");

        // Full FIFO popping its last word while a push arrives
        do_reset();
        word_ready_i = 1'b0;
        blk_valid_i  = 1'b1;
        blk_data_i   = BLK_H;
        step();
        blk_data_i   = BLK_I;
        step();
        blk_valid_i  = 1'b0;
        word_ready_i = 1'b1;
        drain_block("coll H", BLK_H, 0);
        // drain_block stepped through idx 3 already; restart H check is not needed
        // so the collision is staged on the next block instead.
        blk_valid_i = 1'b1;
        blk_data_i  = BLK_J;
        step();
        blk_valid_i = 1'b0;
        check("coll refill count", 128'(count_o),     128'(2'd2));
        check("coll refill ready", 128'(blk_ready_o), 128'(1'b0));
        expect_word("coll I w1", word_of(BLK_I, 1), 1'b0);
        step();
        expect_word("coll I w2", word_of(BLK_I, 2), 1'b0);
        step();
        expect_word("coll I w3", word_of(BLK_I, 3), 1'b1);
        check("coll full", 128'(blk_ready_o), 128'(1'b0));
        check("coll ovf before", 128'(ovf_o), 128'(1'b0));
        blk_valid_i = 1'b1;
        blk_data_i  = BLK_K;
        step();
        check("coll ovf",       128'(ovf_o),       128'(1'b1));
        check("coll count",     128'(count_o),     128'(2'd1));
        check("coll blk_ready", 128'(blk_ready_o), 128'(1'b1));
        blk_data_i = BLK_L;
        expect_word("coll J w0", word_of(BLK_J, 0), 1'b0);
        step();
        blk_valid_i = 1'b0;
        check("coll accept count", 128'(count_o), 128'(2'd2));
        drain_block("coll J", BLK_J, 1);
        drain_block("coll L", BLK_L, 0);
        expect_idle("coll end");
        check("coll end count", 128'(count_o), 128'(2'd0));

        // Reset after the second word of a block
        blk_valid_i = 1'b1;
        blk_data_i  = BLK_A;
        step();
        blk_valid_i = 1'b0;
        expect_word("rst w0", word_of(BLK_A, 0), 1'b0);
        step();
        expect_word("rst w1", word_of(BLK_A, 1), 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_idle("post rst");
        check("post rst ovf",       128'(ovf_o),       128'(1'b0));
        check("post rst count",     128'(count_o),     128'(2'd0));
        check("post rst blk_ready", 128'(blk_ready_o), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            step();
            expect_idle($sformatf("post rst idle%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_word_serializer.md
# inv_word_serializer

Downstream stage of the 128-bit inverse calculator. It captures each completed 128-bit result (`done` / `data_o` from the calculator) into a small block FIFO. It then emits each block as four 32-bit words, most-significant word first, over a valid/ready stream with a last-word marker. The block decouples calculator completion from a narrower, back-pressured consumer and flags any result that arrives while the buffer is full.

## Interface
- `DATA_W`, 128, block width; must equal `WORDS_PER_BLK * WORD_W`.
- `WORD_W`, 32, output word width.
- `DEPTH`, 2, block FIFO depth in blocks; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `blk_valid_i`  in  1  result-valid qualifier; driven by calculator `done`.
- `blk_data_i`  in  DATA_W  result block; driven by calculator `data_o`.
- `blk_ready_o`  out  1  FIFO not full.
- `word_valid_o`  out  1  output word valid.
- `word_ready_i`  in  1  consumer accepts word.
- `word_data_o`  out  WORD_W  output word.
- `word_last_o`  out  1  high with the final (least-significant) word of a block.
- `ovf_o`  out  1  sticky overflow flag.
- `count_o`  out  $clog2(DEPTH)+1  blocks currently buffered, including a partially sent block.

## Operation
- Push: block is written at an edge where `blk_valid_i && blk_ready_o`. Each such cycle is one block; upstream holding `blk_valid_i` for k cycles pushes k copies.
- Overflow: `blk_valid_i && !blk_ready_o` drops the block and sets `ovf_o`. `ovf_o` stays set until `rst`.
- Output FSM:
  - IDLE: FIFO empty; `word_valid_o`=0. Moves to SEND when `count_o`>0.
  - SEND: word index `idx` runs 0..3. `word_data_o = head[DATA_W-1-idx*WORD_W -: WORD_W]`.
  - On each handshake (`word_valid_o && word_ready_i`), `idx` increments.
  - At `idx`=3, `word_last_o`=1. Its handshake pops the head and resets `idx` to 0. The FSM stays in SEND if the FIFO is non-empty after the pop, otherwise returns to IDLE.
- `word_data_o` is forced to 0 whenever `word_valid_o`=0.
- Stream rules:
  - Once `word_valid_o` rises, it stays high, with `word_data_o` and `word_last_o` stable, until the handshake.
  - `word_valid_o` does not depend combinationally on `word_ready_i`.
- No bypass: a block pushed into an empty FIFO is not visible on the output in the same cycle.
- Simultaneous push and pop while full: the push is rejected, because `blk_ready_o` reflects the registered count only. The pop proceeds, and `blk_ready_o` rises the next cycle.
- Simultaneous push and pop otherwise: both occur; `count_o` is unchanged.

## Timing
- Reset values: `blk_ready_o`=1, `word_valid_o`=0, `word_last_o`=0, `word_data_o`=0, `ovf_o`=0, `count_o`=0, `idx`=0, FSM=IDLE.
- Latency: block accepted at edge N gives word 0 valid in cycle N+1.
- Throughput: with `word_ready_i` held high, one word per cycle and one block per 4 cycles, with no bubble between back-to-back blocks.
- `blk_ready_o` deasserts in the cycle after the push that fills the FIFO.
- `rst` mid-block discards the partially sent block and all buffered blocks, with no further words emitted. Outputs take their reset values at the next edge.

## Structure
- Package `inv_pkg` holds:
  - `DATA_W` and `WORD_W` defaults;
  - `WORDS_PER_BLK` = `DATA_W/WORD_W`;
  - `typedef logic [DATA_W-1:0] block_t`;
  - `typedef logic [WORD_W-1:0] word_t`;
  - FSM enum `ser_state_e` {IDLE, SEND}.
- Sub-module `inv_blk_fifo`: DEPTH×`block_t` register FIFO with push/pop, full/empty and count, synchronous active-high reset.
- Top level: FSM, word index, word mux, overflow flag.

## Test plan
- Reset, then push `0000000000000000FFFFFFFFFFFFFFFF` with `word_ready_i`=1. Expect words `00000000`, `00000000`, `FFFFFFFF`, `FFFFFFFF` on consecutive cycles starting one cycle after the push, and `word_last_o` only on the 4th.
- Two back-to-back pushes (`0123456789ABCDEF0011223344556677`, then its inverse) with ready high. Expect 8 consecutive valid words, no gap, and `count_o` sequence 1, 2, 2, 2, 1, 1, 1, 1, 0.
- Fill with `word_ready_i`=0, then push a 3rd block. Expect `blk_ready_o`=0, `ovf_o`=1 held, `count_o`=2, and the 3rd block never emitted.
- Toggle `word_ready_i` 1,0,0,1,… during a block. Expect `word_data_o` stable while stalled and the word order preserved.
- FIFO full and popping the last word, with `blk_valid_i`=1 in the same cycle. Expect the push rejected and `ovf_o`=1. Then `blk_ready_o`=1 next cycle and the next push accepted.
- Assert `rst` after the 2nd word of a block. Expect all outputs at reset values next cycle, no remaining words, and `ovf_o` cleared.
